fifo_rr_drain: RTL and testbench

// Downstream drain stage for two taiga_fifo instances. It arbitrates round-robin

---
 rtl/fifo_rr_drain.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_drain.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain
//
// Drain stage sitting behind two FIFOs. A round-robin arbiter chooses which
// FIFO head to pop each cycle, and the popped entry is written into a 2-entry
// skid buffer whose oldest entry drives a registered valid/ready stream.
// Pops depend only on the buffer occupancy, the arbiter history and the
// source valids, never on out_ready, so the consumer's ready timing does not
// reach back into the FIFO occupancy logic.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous discard of all buffered entries
//   src0_valid - FIFO 0 non-empty
//   src0_data  - FIFO 0 head entry
//   src0_pop   - dequeue FIFO 0 this cycle
//   src1_valid - FIFO 1 non-empty
//   src1_data  - FIFO 1 head entry
//   src1_pop   - dequeue FIFO 1 this cycle
//   out_valid  - oldest buffered entry is valid
//   out_ready  - consumer accepts out_data this cycle
//   out_data   - oldest buffered entry
//   out_src    - which FIFO out_data came from
// ---------------------------------------------------------------------------
module fifo_rr_drain #(
   parameter int DATA_WIDTH = 70
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  src0_valid,
   input  logic [DATA_WIDTH-1:0] src0_data,
   output logic                  src0_pop,
   input  logic                  src1_valid,
   input  logic [DATA_WIDTH-1:0] src1_data,
   output logic                  src1_pop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_src
);

   // Each buffered entry carries its data with the source index in bit 0.
   logic [1:0]          count_q, count_d;
   logic                lastGrant_q, lastGrant_d;
   logic [DATA_WIDTH:0] entry0_q, entry0_d;
   logic [DATA_WIDTH:0] entry1_q, entry1_d;

   logic                space;
   logic                grantVld;
   logic                grantIdx;
   logic                enq;
   logic                deq;
   logic [DATA_WIDTH:0] popEntry;

   // Arbitration and pop generation. Pops are held off while reset is
   // asserted so the FIFOs are never dequeued during reset.
   always_comb begin
      space    = (count_q < 2'd2) & ~flush & rst_n;
      grantVld = 1'b0;
      grantIdx = 1'b0;
      if (src0_valid && src1_valid) begin
         grantVld = 1'b1;
         grantIdx = ~lastGrant_q;
      end else if (src0_valid) begin
         grantVld = 1'b1;
         grantIdx = 1'b0;
      end else if (src1_valid) begin
         grantVld = 1'b1;
         grantIdx = 1'b1;
      end
      src0_pop = space & grantVld & ~grantIdx;
      src1_pop = space & grantVld & grantIdx;
      enq      = src0_pop | src1_pop;
      popEntry = grantIdx ? {src1_data, 1'b1} : {src0_data, 1'b0};
      // A flush discards the whole buffer, so an accept in that cycle is moot.
      deq      = (count_q != 2'd0) & out_ready & ~flush;
   end

   // Next-state for the skid buffer. A new entry lands in entry0 whenever
   // entry0 is empty or being consumed in the same cycle; otherwise it waits
   // in entry1. When full, a dequeue shifts entry1 forward.
   always_comb begin
      count_d     = count_q;
      entry0_d    = entry0_q;
      entry1_d    = entry1_q;
      lastGrant_d = enq ? grantIdx : lastGrant_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (enq) begin
                  entry0_d = popEntry;
                  count_d  = 2'd1;
               end
            end
            2'd1: begin
               if (enq && !deq) begin
                  entry1_d = popEntry;
                  count_d  = 2'd2;
               end else if (enq && deq) begin
                  entry0_d = popEntry;
               end else if (deq) begin
                  count_d = 2'd0;
               end
            end
            2'd2: begin
               if (deq) begin
                  entry0_d = entry1_q;
                  count_d  = 2'd1;
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   // Control state. last grant resets to source 1 so that source 0 wins the
   // first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         lastGrant_q <= 1'b1;
      end else begin
         count_q     <= count_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Entry storage is qualified by count, so it needs no reset.
   always_ff @(posedge clk) begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
   end

   assign out_valid = (count_q != 2'd0);
   assign out_data  = entry0_q[DATA_WIDTH:1];
   assign out_src   = entry0_q[0];

endmodule

// File: tb/tb_fifo_rr_drain.sv
module tb_fifo_rr_drain;

   localparam int DW = 70;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          src0_valid;
   logic [DW-1:0] src0_data;
   logic          src0_pop;
   logic          src1_valid;
   logic [DW-1:0] src1_data;
   logic          src1_pop;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_src;

   int compared;
   int mismatched;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic          sawPop0;
   logic          sawPop1;

   fifo_rr_drain #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .src0_valid(src0_valid),
      .src0_data (src0_data),
      .src0_pop  (src0_pop),
      .src1_valid(src1_valid),
      .src1_data (src1_data),
      .src1_pop  (src1_pop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   // Free-running clock: rising edges at 5, 15, 25 ... falling edges at 10, 20 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Distinct 70-bit word with the id in both the low and the top bits.
   function automatic logic [DW-1:0] word(input logic [7:0] id);
      return {id[5:0], 56'h0, id};
   endfunction

   task automatic checkOutput(input string tag, input logic [71:0] observed,
                              input logic [71:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present the current head of each modelled FIFO to the DUT.
   task automatic driveSources();
      src0_valid = (q0.size() > 0);
      src0_data  = (q0.size() > 0) ? q0[0] : '0;
      src1_valid = (q1.size() > 0);
      src1_data  = (q1.size() > 0) ? q1[0] : '0;
   endtask

   // One clock cycle: check pops and the output stream at the falling edge,
   // then let the rising edge happen and retire whatever the DUT popped.
   task automatic applyStimulus(input string tag, input logic ePop0, input logic ePop1,
                                input logic eValid, input logic [DW-1:0] eData,
                                input logic eSrc);
      @(negedge clk);
      checkOutput({tag, ".pop0"}, 72'(src0_pop), 72'(ePop0));
      checkOutput({tag, ".pop1"}, 72'(src1_pop), 72'(ePop1));
      checkOutput({tag, ".valid"}, 72'(out_valid), 72'(eValid));
      if (eValid) begin
         checkOutput({tag, ".data"}, 72'(out_data), 72'(eData));
         checkOutput({tag, ".src"}, 72'(out_src), 72'(eSrc));
      end
      sawPop0 = src0_pop;
      sawPop1 = src1_pop;
      @(posedge clk);
      #1;
      if (sawPop0 && q0.size() > 0) void'(q0.pop_front());
      if (sawPop1 && q1.size() > 0) void'(q1.pop_front());
      driveSources();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      rst_n      = 1'b1;
      q0.push_back(word(8'h01));
      driveSources();

      // Asynchronous reset: outputs must clear without a clock edge.
      #1 rst_n = 1'b0;
      #1;
      $display("[TB] reset checks");
      checkOutput("rst.pop0", 72'(src0_pop), 72'd0);
      checkOutput("rst.pop1", 72'(src1_pop), 72'd0);
      checkOutput("rst.valid", 72'(out_valid), 72'd0);
      q0.delete();
      @(posedge clk);
      @(posedge clk);
      #2;
      driveSources();
      rst_n = 1'b1;

      // Fairness: both sources valid, tie goes to source 0 first after reset.
      $display("[TB] fairness");
      q0.push_back(word(8'hA0)); q0.push_back(word(8'hA1));
      q1.push_back(word(8'hB0)); q1.push_back(word(8'hB1));
      driveSources();
      applyStimulus("fair1", 1, 0, 0, '0, 0);
      applyStimulus("fair2", 0, 1, 1, word(8'hA0), 0);
      applyStimulus("fair3", 1, 0, 1, word(8'hB0), 1);
      applyStimulus("fair4", 0, 1, 1, word(8'hA1), 0);
      applyStimulus("fair5", 0, 0, 1, word(8'hB1), 1);
      applyStimulus("fair6", 0, 0, 0, '0, 0);

      // Single stream from source 0 with the consumer always ready.
      $display("[TB] single stream");
      q0.push_back(word(8'h0A)); q0.push_back(word(8'h0B)); q0.push_back(word(8'h0C));
      driveSources();
      applyStimulus("single1", 1, 0, 0, '0, 0);
      applyStimulus("single2", 1, 0, 1, word(8'h0A), 0);
      applyStimulus("single3", 1, 0, 1, word(8'h0B), 0);
      applyStimulus("single4", 0, 0, 1, word(8'h0C), 0);
      applyStimulus("single5", 0, 0, 0, '0, 0);

      // Backpressure: two pops fill the buffer, then release the consumer.
      $display("[TB] backpressure");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) q0.push_back(word(8'h10 + 8'(i)));
      driveSources();
      applyStimulus("bp1", 1, 0, 0, '0, 0);
      applyStimulus("bp2", 1, 0, 1, word(8'h10), 0);
      applyStimulus("bp3", 0, 0, 1, word(8'h10), 0);
      applyStimulus("bp4", 0, 0, 1, word(8'h10), 0);
      out_ready = 1'b1;
      applyStimulus("bp5", 0, 0, 1, word(8'h10), 0);
      applyStimulus("bp6", 1, 0, 1, word(8'h11), 0);
      applyStimulus("bp7", 1, 0, 1, word(8'h12), 0);
      applyStimulus("bp8", 1, 0, 1, word(8'h13), 0);
      applyStimulus("bp9", 0, 0, 1, word(8'h14), 0);
      applyStimulus("bp10", 0, 0, 0, '0, 0);

      // Flush at full and at one entry; arbitration history survives flush.
      $display("[TB] flush");
      out_ready = 1'b0;
      q0.push_back(word(8'h20)); q0.push_back(word(8'h21)); q0.push_back(word(8'h22));
      q1.push_back(word(8'h30)); q1.push_back(word(8'h31));
      driveSources();
      applyStimulus("fl1", 0, 1, 0, '0, 0);
      applyStimulus("fl2", 1, 0, 1, word(8'h30), 1);
      flush = 1'b1;
      applyStimulus("fl3", 0, 0, 1, word(8'h30), 1);
      flush = 1'b0;
      applyStimulus("fl4", 0, 1, 0, '0, 0);
      flush     = 1'b1;
      out_ready = 1'b1;
      applyStimulus("fl5", 0, 0, 1, word(8'h31), 1);
      flush = 1'b0;
      applyStimulus("fl6", 1, 0, 0, '0, 0);
      applyStimulus("fl7", 1, 0, 1, word(8'h21), 0);
      applyStimulus("fl8", 0, 0, 1, word(8'h22), 0);
      applyStimulus("fl9", 0, 0, 0, '0, 0);

      // Mid-stream async reset with one entry buffered.
      $display("[TB] mid-stream reset");
      q0.push_back(word(8'h40));
      driveSources();
      applyStimulus("mr1", 1, 0, 0, '0, 0);
      q0.push_back(word(8'h41));
      q1.push_back(word(8'h50));
      driveSources();
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mr.valid", 72'(out_valid), 72'd0);
      checkOutput("mr.pop0", 72'(src0_pop), 72'd0);
      checkOutput("mr.pop1", 72'(src1_pop), 72'd0);
      #1 rst_n = 1'b1;
      applyStimulus("mr2", 1, 0, 0, '0, 0);
      applyStimulus("mr3", 0, 1, 1, word(8'h41), 0);
      applyStimulus("mr4", 0, 0, 1, word(8'h50), 1);
      applyStimulus("mr5", 0, 0, 0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
